vending_return_ctrl: RTL and testbench

Holds the vending machine's running balance and returns change. It sits directly downstream of the coin-total adder: each cycle the adder's next-total result is loaded here, and this block owns the inactivity timeout. On an explicit return request or a timeout, it pays out the balance greedily, one coin per clock, largest denomination first, then clears.

---
 rtl/vending_return_ctrl_if.sv | 23 ++
 rtl/vending_return_ctrl.sv | 92 +++++++++
 tb/tb_vending_return_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/vending_return_ctrl_if.sv
// Balance/payout bus between the coin-total adder, the front panel and the return controller.
interface vending_return_ctrl_if #(
  parameter int unsigned TOTAL_BITS = 31
);
  logic                  i_load;
  logic [TOTAL_BITS-1:0] i_total;
  logic                  i_activity;
  logic                  i_trigger_return;
  logic [TOTAL_BITS-1:0] o_total;
  logic [2:0]            o_return_coin;
  logic                  o_busy;
  logic                  o_done;

  modport master (
    output i_load, i_total, i_activity, i_trigger_return,
    input  o_total, o_return_coin, o_busy, o_done
  );

  modport slave (
    input  i_load, i_total, i_activity, i_trigger_return,
    output o_total, o_return_coin, o_busy, o_done
  );
endinterface

// File: rtl/vending_return_ctrl.sv
// Balance register with inactivity timeout and greedy one-coin-per-clock change payout.
module vending_return_ctrl #(
  parameter int unsigned TOTAL_BITS  = 31,
  parameter int unsigned COIN0       = 100,
  parameter int unsigned COIN1       = 500,
  parameter int unsigned COIN2       = 1000,
  parameter int unsigned WAIT_CYCLES = 10
) (
  input logic                 clk,
  input logic                 reset_n,
  vending_return_ctrl_if.slave bus
);
  localparam int unsigned CNT_BITS = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RETURN, ST_DONE} state_t;

  state_t                state, state_n;
  logic [TOTAL_BITS-1:0] bal, bal_n;
  logic [CNT_BITS-1:0]   cnt, cnt_n;
  logic [2:0]            coin, coin_n;
  logic                  busy, done;

  // State, balance, timeout and coin registers; busy/done follow the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      bal   <= '0;
      cnt   <= '0;
      coin  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      bal   <= bal_n;
      cnt   <= cnt_n;
      coin  <= coin_n;
      busy  <= (state_n != ST_IDLE);
      done  <= (state_n == ST_DONE);
    end
  end

  // Next-state and payout decision
  always_comb begin
    state_n = state;
    bal_n   = bal;
    cnt_n   = cnt;
    coin_n  = 3'b000;
    unique case (state)
      ST_IDLE: begin
        if (bus.i_load) bal_n = bus.i_total;
        if (bus.i_trigger_return) begin
          state_n = ST_RETURN;
          cnt_n   = '0;
        end else if (bus.i_load || bus.i_activity) begin
          cnt_n = '0;
        end else if (bal != '0) begin
          if (cnt == CNT_BITS'(WAIT_CYCLES - 1)) begin
            state_n = ST_RETURN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_BITS'(1);
          end
        end else begin
          cnt_n = '0;
        end
      end
      ST_RETURN: begin
        // Compare before subtract so the balance can never wrap
        if (bal >= TOTAL_BITS'(COIN2)) begin
          bal_n  = bal - TOTAL_BITS'(COIN2);
          coin_n = 3'b100;
        end else if (bal >= TOTAL_BITS'(COIN1)) begin
          bal_n  = bal - TOTAL_BITS'(COIN1);
          coin_n = 3'b010;
        end else if (bal >= TOTAL_BITS'(COIN0)) begin
          bal_n  = bal - TOTAL_BITS'(COIN0);
          coin_n = 3'b001;
        end else begin
          bal_n   = '0;
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.o_total       = bal;
  assign bus.o_return_coin = coin;
  assign bus.o_busy        = busy;
  assign bus.o_done        = done;
endmodule

// File: tb/tb_vending_return_ctrl.sv
// Scoreboard bench: expected payout events queued at stimulus time, checked as coins/done appear.
module tb_vending_return_ctrl;
  localparam int unsigned TB = 31;

  typedef struct {
    logic [2:0]    coin;
    logic [TB-1:0] total;
    logic          is_done;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n;
  logic saw_busy;
  ev_t  sb[$];

  vending_return_ctrl_if #(.TOTAL_BITS(TB)) bus ();

  vending_return_ctrl #(
    .TOTAL_BITS(TB), .COIN0(100), .COIN1(500), .COIN2(1000), .WAIT_CYCLES(10)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent greedy model of the payout sequence for balance r
  task automatic push_payout(input int unsigned r);
    int unsigned b = r;
    ev_t e;
    while (b >= 100) begin
      if (b >= 1000) begin e.coin = 3'b100; b -= 1000; end
      else if (b >= 500) begin e.coin = 3'b010; b -= 500; end
      else begin e.coin = 3'b001; b -= 100; end
      e.total = TB'(b); e.is_done = 1'b0;
      sb.push_back(e);
    end
    e.coin = 3'b000; e.total = '0; e.is_done = 1'b1;
    sb.push_back(e);
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!bus.o_done && cnt < 50) begin
      tick();
      cnt++;
    end
  endtask

  // Monitor: every coin or done pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset_n && (bus.o_return_coin != 3'b000 || bus.o_done)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_event", 32'(bus.o_return_coin), 32'(0));
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("coin", 32'(bus.o_return_coin), 32'(e.coin));
        check("coin_total", 32'(bus.o_total), 32'(e.total));
        check("done_flag", 32'(bus.o_done), 32'(e.is_done));
      end
    end
  end

  initial begin
    bus.i_load = 1'b0; bus.i_total = '0; bus.i_activity = 1'b0; bus.i_trigger_return = 1'b0;
    #2;
    check("rst_total", 32'(bus.o_total), 0);
    check("rst_coin", 32'(bus.o_return_coin), 0);
    check("rst_busy", 32'(bus.o_busy), 0);
    check("rst_done", 32'(bus.o_done), 0);
    #10 reset_n = 1'b1;
    tick();

    // Load 1600, trigger next cycle: 1000, 500, 100
    bus.i_load = 1'b1; bus.i_total = TB'(1600);
    tick();
    bus.i_load = 1'b0;
    check("load_total", 32'(bus.o_total), 1600);
    push_payout(1600);
    bus.i_trigger_return = 1'b1;
    tick();
    bus.i_trigger_return = 1'b0;
    check("trig_busy", 32'(bus.o_busy), 1);
    check("trig_no_coin", 32'(bus.o_return_coin), 0);
    wait_done(n);
    check("done_lat_1600", 32'(n), 4);
    check("done_busy_1600", 32'(bus.o_busy), 1);
    tick();
    check("idle_busy_1600", 32'(bus.o_busy), 0);
    check("idle_done_1600", 32'(bus.o_done), 0);

    // Load 250 and let the timeout expire
    push_payout(250);
    bus.i_load = 1'b1; bus.i_total = TB'(250);
    tick();
    bus.i_load = 1'b0;
    n = 0;
    while (!bus.o_busy && n < 30) begin tick(); n++; end
    check("timeout_250", 32'(n), 10);
    wait_done(n);
    check("done_lat_250", 32'(n), 3);
    check("final_total_250", 32'(bus.o_total), 0);
    tick();

    // Load 500, activity every 5 cycles keeps the timeout from expiring
    bus.i_load = 1'b1; bus.i_total = TB'(500);
    tick();
    bus.i_load = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.i_activity = (i % 5 == 4);
      tick();
      if (bus.o_busy) saw_busy = 1'b1;
    end
    bus.i_activity = 1'b0;
    check("activity_no_return", 32'(saw_busy), 0);
    push_payout(500);
    n = 0;
    while (!bus.o_busy && n < 30) begin tick(); n++; end
    check("timeout_after_activity", 32'(n), 10);
    wait_done(n);
    check("done_lat_500", 32'(n), 2);
    tick();

    // Load 2000 and trigger on the same edge
    push_payout(2000);
    bus.i_load = 1'b1; bus.i_total = TB'(2000); bus.i_trigger_return = 1'b1;
    tick();
    bus.i_load = 1'b0; bus.i_trigger_return = 1'b0;
    check("same_edge_total", 32'(bus.o_total), 2000);
    wait_done(n);
    check("done_lat_2000", 32'(n), 3);
    check("final_total_2000", 32'(bus.o_total), 0);
    tick();

    // Trigger with zero balance; load during RETURN is ignored
    push_payout(0);
    bus.i_trigger_return = 1'b1;
    tick();
    bus.i_trigger_return = 1'b0;
    check("zero_busy", 32'(bus.o_busy), 1);
    bus.i_load = 1'b1; bus.i_total = TB'(777);
    tick();
    bus.i_load = 1'b0;
    check("zero_done_n1", 32'(bus.o_done), 1);
    check("zero_load_ignored", 32'(bus.o_total), 0);
    tick();
    check("zero_idle_busy", 32'(bus.o_busy), 0);
    check("zero_idle_total", 32'(bus.o_total), 0);

    // Asynchronous reset in the middle of a payout
    push_payout(3000);
    bus.i_load = 1'b1; bus.i_total = TB'(3000); bus.i_trigger_return = 1'b1;
    tick();
    bus.i_load = 1'b0; bus.i_trigger_return = 1'b0;
    tick();
    check("pre_rst_total", 32'(bus.o_total), 2000);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_total", 32'(bus.o_total), 0);
    check("mid_rst_coin", 32'(bus.o_return_coin), 0);
    check("mid_rst_busy", 32'(bus.o_busy), 0);
    check("mid_rst_done", 32'(bus.o_done), 0);
    sb.delete();
    tick();
    reset_n = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.o_busy || bus.o_return_coin != 3'b000) saw_busy = 1'b1;
    end
    check("post_rst_quiet", 32'(saw_busy), 0);
    check("post_rst_total", 32'(bus.o_total), 0);

    check("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
